// File: rtl/div_sqrt_iterative_core_if.sv
// Handshake and operand/result bundle for the iterative divide/sqrt core.
// The core takes the slave side; the operand-prep stage and the rounding
// unit together drive the master side.
interface div_sqrt_iterative_core_if #(
  parameter int FRAC_W = 23
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              op_sqrt;
  logic [FRAC_W+1:0] dividend;
  logic [FRAC_W:0]   divisor;
  logic              out_valid;
  logic              out_ready;
  logic [FRAC_W+2:0] quotient;
  logic [FRAC_W+3:0] remainder;

  modport slave (
    input  flush, in_valid, op_sqrt, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder
  );

  modport master (
    output flush, in_valid, op_sqrt, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/div_sqrt_iterative_core.sv
// Restoring radix-2 significand divider / square-rooter.
// Produces one quotient/root bit per cycle (26 iterations) plus the final
// partial remainder so the rounding stage can derive sticky.
module div_sqrt_iterative_core #(
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  div_sqrt_iterative_core_if.slave bus
);
  localparam int QW    = FRAC_W + 3;   // quotient/root width
  localparam int RW    = FRAC_W + 4;   // remainder output width
  localparam int DW    = FRAC_W + 2;   // dividend width
  localparam int BW    = FRAC_W + 1;   // divisor width
  localparam int ITER  = QW;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q;
  logic [BW-1:0]    div_q;
  logic [QW-1:0]    x_q;     // radicand bits still to be consumed, MSB pair first
  logic [QW-1:0]    r_q;     // partial remainder between iterations
  logic [QW-1:0]    q_q;     // quotient/root developed so far
  logic [CNT_W-1:0] cnt_q;
  logic [QW-1:0]    quot_q;
  logic [RW-1:0]    rem_q;

  logic             accept, step, last;
  logic             d_ge, s_ge;
  logic [DW-1:0]    d_rem;
  logic [QW+1:0]    s_sh, s_t;
  logic [RW-1:0]    s_rem;
  logic [QW-1:0]    q_nx, r_nx;
  logic [RW-1:0]    rem_nx;

  assign accept = (state_q == S_IDLE) && bus.in_valid && !bus.flush;
  assign step   = (state_q == S_RUN) && !bus.flush;
  assign last   = (cnt_q == CNT_W'(ITER - 1));

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_RUN;
      S_RUN:   if (last)         state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  // One restoring iteration for both operations.
  // The div remainder stays below the divisor, so it fits in DW bits before
  // the shift. The sqrt difference is only kept when non-negative and then
  // is bounded by 2q, so the low RW bits of the subtraction are exact.
  always_comb begin
    d_ge  = (r_q >= {{(QW - BW){1'b0}}, div_q});
    d_rem = d_ge ? (r_q[DW-1:0] - {1'b0, div_q}) : r_q[DW-1:0];
    s_sh  = {r_q, x_q[QW-1 -: 2]};
    s_t   = {q_q, 2'b01};
    s_ge  = (s_sh >= s_t);
    s_rem = s_ge ? (s_sh[RW-1:0] - s_t[RW-1:0]) : s_sh[RW-1:0];
    if (op_q) begin
      q_nx   = {q_q[QW-2:0], s_ge};
      r_nx   = s_rem[QW-1:0];
      rem_nx = s_rem;
    end else begin
      q_nx   = {q_q[QW-2:0], d_ge};
      r_nx   = {d_rem, 1'b0};
      rem_nx = {{(RW - DW){1'b0}}, d_rem};
    end
  end

  // Datapath: latch operands on accept, iterate in RUN, capture the result
  // on the last iteration. A flush leaves the previous result untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= 1'b0;
      div_q  <= '0;
      x_q    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      op_q  <= bus.op_sqrt;
      div_q <= bus.divisor;
      x_q   <= {bus.dividend, 1'b0};
      r_q   <= bus.op_sqrt ? '0 : {1'b0, bus.dividend};
      q_q   <= '0;
      cnt_q <= '0;
    end else if (step) begin
      q_q   <= q_nx;
      r_q   <= r_nx;
      x_q   <= {x_q[QW-3:0], 2'b00};
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        quot_q <= q_nx;
        rem_q  <= rem_nx;
      end
    end
  end
endmodule
